pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised successor of the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic payload through DEPTH register slots, with per-slot valid bits, valid/ready flow control, bubble collapsing, flush and global freeze.
- Control bits held in slots that carry no valid instruction are forced to zero, so a stalled or flushed slot never issues spurious writes downstream.
- One instance sits between each pair of pipeline stages.

Parameters:
- DATA_W, 64, total payload width in bits.
- CTRL_W, 8, payload bits [CTRL_W-1:0] are control (wb_en, mem_w_en, br_taken, ...); these are cleared in invalid slots. Legal range 0..DATA_W.
- DEPTH, 1, number of register slots, 1..4. DEPTH=1 behaves as a classic stage register plus valid.
- OCC_W, 3, occupancy width; must be >= clog2(DEPTH+1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low: state clears on a clk edge while rst=0
- freez  in  1  global hazard freeze; holds all state
- flush  in  1  discard all in-flight entries (branch taken)
- in_valid  in  1  upstream offers in_data
- in_ready  out  1  buffer accepts in_data this cycle
- in_data  in  DATA_W  payload from upstream stage
- out_valid  out  1  slot DEPTH-1 holds a valid entry
- out_ready  in  1  downstream consumes the entry this cycle
- out_data  out  DATA_W  payload of slot DEPTH-1
- occupancy  out  OCC_W  number of valid slots

Behaviour:
- State: v[i] and d[i] for i=0..DEPTH-1. Slot 0 is the input side; slot DEPTH-1 drives out_valid/out_data directly. No combinational path from in_data to out_data.
- Reset (rst=0 at a clk edge): all v=0, all d=0. Outputs follow: out_valid=0, out_data=0, occupancy=0. in_ready=0 while rst=0. Reset overrides flush and freez, including mid-transfer.
- Slot advance condition, combinational: rdy[DEPTH]=out_ready; rdy[i] = !v[i] | rdy[i+1]. Bubble collapsing: an empty slot always accepts from upstream, even when downstream is stalled.
- in_ready = rdy[0] & !freez & !flush.
- Handshakes:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready & !freez & !flush.
  - in_ready may depend on out_ready; it never depends on in_valid.
- Normal cycle (rst=1, flush=0, freez=0), for each slot i with rdy[i]=1:
  - Slot 0 loads in_data when in_valid=1.
  - Slot i>0 loads d[i-1] when v[i-1]=1.
  - Otherwise the slot becomes invalid: v[i]=0, d[i][CTRL_W-1:0]=0, upper data bits hold.
  - Slots with rdy[i]=0 hold.
- Latency: an entry accepted into an empty buffer appears at out_valid DEPTH cycles later. Throughput is one entry per cycle while out_ready=1.
- freez=1 (flush=0): no register changes, matching the legacy freeze semantics. out_valid and out_data hold. No output transfer occurs regardless of out_ready.
- flush=1: next edge sets all v=0 and clears every d[i][CTRL_W-1:0]; upper bits hold.
  - flush has priority over freez.
  - Input presented during the flush cycle is not accepted (in_ready=0).
  - Flush and reset both take effect in one cycle; there is no drain phase.
- Full boundary: all v=1 and out_ready=0 -> in_ready=0, and all slots hold.
- Full with out_ready=1: simultaneous output and input transfers; occupancy is unchanged.
- Empty boundary: out_valid=0, and out_data control bits are 0.
- occupancy = popcount(v); combinational from registers only. Range 0..DEPTH; it never wraps.
- CTRL_W=0: no bits are cleared; only v changes.

Decomposition:
- Shared include file pipe_defs.vh: payload field offsets/widths per stage boundary (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W), the CTRL_W value for each boundary, and a MAX_PIPE_DEPTH=4 constant.
- One sub-module, pipe_slot: a single slot holding v and d, with inputs load, load_valid and clear (control bits + v). pipe_stage_buf instantiates DEPTH pipe_slot instances via a generate loop and computes the rdy chain.

Test Plan (DATA_W=16, CTRL_W=4 unless noted):
- Reset: drive rst=0 for 2 cycles with in_valid=1 and in_data=16'hFFFF -> out_valid=0, out_data=16'h0000, occupancy=0, in_ready=0. After rst=1, first entry 16'h1235 appears at out_valid after DEPTH cycles (DEPTH=1 and DEPTH=3 runs).
- Streaming (DEPTH=3): push 16'h0001..16'h0008 back-to-back with out_ready=1 -> outputs arrive in order on consecutive cycles, starting 3 cycles after the first accept. occupancy=3 in steady state.
- Backpressure/collapse (DEPTH=3): fill slot 2 only, hold out_ready=0, push 2 entries -> both accepted (bubbles collapse), occupancy=3, then in_ready=0. Release out_ready -> entries drain in order and in_ready=1 the same cycle.
- Freeze: with occupancy=2, hold freez=1 for 3 cycles with out_ready=1 and in_valid=1 -> no transfers, out_data stable, occupancy stays 2, in_ready=0.
- Flush beats freeze: occupancy=3 with d[2]=16'hABCF; assert flush=1 and freez=1 together -> next cycle out_valid=0, out_data=16'hABC0, occupancy=0. The in_data presented that cycle is not accepted.
- Bubble control clear: DEPTH=2, send 16'h5A5F then in_valid=0 with out_ready=1 -> after the entry leaves, out_valid=0 and out_data[3:0]=0 while out_data[15:4]=12'h5A5.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: payload widths
// per stage boundary, their control-field widths, and the slot action type.
package pipe_stage_buf_pkg;

   // Payload widths at each boundary of the classic five-stage pipeline
   localparam int IF_ID_W   = 64;  // pc + instruction
   localparam int ID_EX_W   = 128; // pc + rs1/rs2 values + imm
   localparam int EX_MEM_W  = 80;  // alu result + store data + ctrl
   localparam int MEM_WB_W  = 48;  // writeback value + rd + ctrl

   // Low-order control bits per boundary that must vanish in empty slots
   localparam int IF_ID_CTRL_W  = 0;
   localparam int ID_EX_CTRL_W  = 8;
   localparam int EX_MEM_CTRL_W = 8;
   localparam int MEM_WB_CTRL_W = 8;

   localparam int MAX_PIPE_DEPTH = 4;

   // What a slot does on the next clock edge
   typedef enum logic [1:0] {
      SLOT_HOLD  = 2'd0,
      SLOT_LOAD  = 2'd1,
      SLOT_CLEAR = 2'd2
   } slot_op_e;

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// One register slot of the pipeline buffer: a valid bit plus payload.
// Whenever the slot ends up empty its control bits are zeroed so nothing
// downstream can act on stale write enables.
module pipe_slot
   import pipe_stage_buf_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              load_valid,
   input  logic              clear,
   input  logic [DATA_W-1:0] din,
   output logic              slot_v,
   output logic [DATA_W-1:0] slot_data
);

   localparam logic [DATA_W-1:0] CTRL_MASK =
      (CTRL_W == 0) ? '0 : ({DATA_W{1'b1}} >> (DATA_W - CTRL_W));

   slot_op_e          op;
   logic              v_d, v_q;
   logic [DATA_W-1:0] d_d, d_q;

   // Decide the slot action and its next value; clear wins over load
   always_comb begin
      op  = SLOT_HOLD;
      v_d = v_q;
      d_d = d_q;
      if (clear)     op = SLOT_CLEAR;
      else if (load) op = SLOT_LOAD;
      case (op)
         SLOT_CLEAR: begin
            v_d = 1'b0;
            d_d = d_q & ~CTRL_MASK;
         end
         SLOT_LOAD: begin
            v_d = load_valid;
            d_d = load_valid ? din : (d_q & ~CTRL_MASK);
         end
         default: begin
            v_d = v_q;
            d_d = d_q;
         end
      endcase
   end

   // Slot state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         v_q <= 1'b0;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign slot_v    = v_q;
   assign slot_data = d_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised inter-stage pipeline buffer: DEPTH slots with valid/ready
// flow control, bubble collapsing, flush and global freeze. The output is
// taken straight from the last slot, so there is no in_data->out_data path.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 8,
   parameter int DEPTH  = 1,
   parameter int OCC_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freez,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [OCC_W-1:0]  occupancy
);

   logic [DEPTH:0]    rdy;
   logic              advance;
   logic [DEPTH-1:0]  slot_v;
   logic [DATA_W-1:0] slot_data [DEPTH];
   logic [OCC_W-1:0]  occ_c;

   // Ready chain from the output side back: an empty slot always accepts
   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         rdy[i] = !slot_v[i] | rdy[i+1];
      end
   end

   assign advance  = !freez & !flush;
   assign in_ready = rst & rdy[0] & advance;

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      logic              src_v;
      logic [DATA_W-1:0] src_d;
      if (g == 0) begin : g_head
         assign src_v = in_valid;
         assign src_d = in_data;
      end else begin : g_body
         assign src_v = slot_v[g-1];
         assign src_d = slot_data[g-1];
      end
      pipe_slot #(
         .DATA_W (DATA_W),
         .CTRL_W (CTRL_W)
      ) u_slot (
         .clk        (clk),
         .rst        (rst),
         .load       (advance & rdy[g]),
         .load_valid (src_v),
         .clear      (flush),
         .din        (src_d),
         .slot_v     (slot_v[g]),
         .slot_data  (slot_data[g])
      );
   end

   // Occupancy is the population count of the slot valid bits
   always_comb begin
      occ_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_c = occ_c + OCC_W'(slot_v[i]);
      end
   end

   assign occupancy = occ_c;
   assign out_valid = slot_v[DEPTH-1];
   assign out_data  = slot_data[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: DEPTH=1, 2 and 3 instances share one
// stimulus bus; each test checks the instance it targets.
module tb_pipe_stage_buf;

   logic        clk = 1'b0;
   logic        rst, freez, flush, in_valid, out_ready;
   logic [15:0] in_data;

   logic        ir1, ov1, ir2, ov2, ir3, ov3;
   logic [15:0] od1, od2, od3;
   logic [2:0]  occ1, occ2, occ3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(16), .CTRL_W(4), .DEPTH(1), .OCC_W(3)) dut1 (
      .clk(clk), .rst(rst), .freez(freez), .flush(flush),
      .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1));

   pipe_stage_buf #(.DATA_W(16), .CTRL_W(4), .DEPTH(2), .OCC_W(3)) dut2 (
      .clk(clk), .rst(rst), .freez(freez), .flush(flush),
      .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
      .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .occupancy(occ2));

   pipe_stage_buf #(.DATA_W(16), .CTRL_W(4), .DEPTH(3), .OCC_W(3)) dut3 (
      .clk(clk), .rst(rst), .freez(freez), .flush(flush),
      .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
      .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .occupancy(occ3));

   typedef struct {
      logic        rst, frz, fl, iv;
      logic [15:0] din;
      logic        ordy;
      logic        ir, ov;
      logic [15:0] od;
      logic [2:0]  occ;
   } vec_t;

   localparam int NV = 21;
   vec_t tbl [NV];

   function automatic vec_t mk(logic r, logic fz, logic fl, logic iv,
                               logic [15:0] din, logic ordy, logic ir,
                               logic ov, logic [15:0] od, logic [2:0] occ);
      vec_t v;
      v.rst = r; v.frz = fz; v.fl = fl; v.iv = iv; v.din = din;
      v.ordy = ordy; v.ir = ir; v.ov = ov; v.od = od; v.occ = occ;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic r, logic fz, logic fl, logic iv, logic [15:0] d, logic ordy);
      rst = r; freez = fz; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
      repeat (2) tick();
   endtask

   initial begin
      // rst frz fl iv din ordy | ir ov od occ  (outputs observed before edge)
      tbl[0]  = mk(0,0,0,1,16'hFFFF,0, 0,0,16'h0000,0); // held in reset
      tbl[1]  = mk(1,0,0,1,16'h1235,0, 1,0,16'h0000,0); // first accept
      tbl[2]  = mk(1,0,0,0,16'h0000,0, 1,0,16'h0000,1);
      tbl[3]  = mk(1,0,0,0,16'h0000,0, 1,0,16'h0000,1);
      tbl[4]  = mk(1,0,0,0,16'h0000,0, 1,1,16'h1235,1); // 3 cycles later
      tbl[5]  = mk(1,0,0,1,16'h2223,0, 1,1,16'h1235,1); // collapse bubbles
      tbl[6]  = mk(1,0,0,1,16'h3334,0, 1,1,16'h1235,2);
      tbl[7]  = mk(1,0,0,1,16'h4445,0, 0,1,16'h1235,3); // full, stalled
      tbl[8]  = mk(1,0,0,1,16'h4445,1, 1,1,16'h1235,3); // release: ready same cycle
      tbl[9]  = mk(1,0,0,0,16'h0000,1, 1,1,16'h2223,3);
      tbl[10] = mk(1,0,0,1,16'hABCF,1, 1,1,16'h3334,2);
      tbl[11] = mk(1,1,0,1,16'h6667,1, 0,1,16'h4445,2); // freeze x3
      tbl[12] = mk(1,1,0,1,16'h6667,1, 0,1,16'h4445,2);
      tbl[13] = mk(1,1,0,1,16'h6667,1, 0,1,16'h4445,2);
      tbl[14] = mk(1,0,0,1,16'h7778,1, 1,1,16'h4445,2);
      tbl[15] = mk(1,0,0,1,16'h8889,0, 1,0,16'h4440,2);
      tbl[16] = mk(1,1,1,1,16'h9999,1, 0,1,16'hABCF,3); // flush beats freeze
      tbl[17] = mk(1,0,0,0,16'h0000,0, 1,0,16'hABC0,0);
      tbl[18] = mk(1,0,0,0,16'h0000,0, 1,0,16'hABC0,0);
      tbl[19] = mk(0,1,1,1,16'hFFFF,1, 0,0,16'hABC0,0); // reset beats all
      tbl[20] = mk(1,0,0,0,16'h0000,0, 1,0,16'h0000,0);

      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      do_reset();

      // Table-driven run on the DEPTH=3 instance
      for (int r = 0; r < NV; r++) begin
         drive(tbl[r].rst, tbl[r].frz, tbl[r].fl, tbl[r].iv, tbl[r].din, tbl[r].ordy);
         #1;
         chk($sformatf("tbl%0d in_ready", r),  32'(ir3),  32'(tbl[r].ir));
         chk($sformatf("tbl%0d out_valid", r), 32'(ov3),  32'(tbl[r].ov));
         chk($sformatf("tbl%0d out_data", r),  32'(od3),  32'(tbl[r].od));
         chk($sformatf("tbl%0d occupancy", r), 32'(occ3), 32'(tbl[r].occ));
         tick();
      end

      // Streaming 1..8 through DEPTH=3 with out_ready held high
      do_reset();
      for (int c = 0; c < 13; c++) begin
         int acc, dep;
         drive(1'b1, 1'b0, 1'b0, (c < 8), 16'(c + 1), 1'b1);
         #1;
         acc = (c < 8) ? c : 8;
         dep = (c < 3) ? 0 : ((c - 3 > 8) ? 8 : c - 3);
         chk($sformatf("stream%0d out_valid", c), 32'(ov3), 32'((c >= 3) && (c < 11)));
         if (c >= 3 && c < 11)
            chk($sformatf("stream%0d out_data", c), 32'(od3), 32'(c - 2));
         chk($sformatf("stream%0d occupancy", c), 32'(occ3), 32'(acc - dep));
         chk($sformatf("stream%0d in_ready", c), 32'(ir3), 32'd1);
         tick();
      end

      // DEPTH=1: classic stage register plus valid
      do_reset();
      chk("d1 reset out_valid", 32'(ov1), 32'd0);
      chk("d1 reset in_ready", 32'(ir1), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h1235, 1'b1);
      #1;
      chk("d1 in_ready", 32'(ir1), 32'd1);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      #1;
      chk("d1 out_valid", 32'(ov1), 32'd1);
      chk("d1 out_data", 32'(od1), 32'h1235);
      chk("d1 occupancy", 32'(occ1), 32'd1);
      tick();
      chk("d1 drained out_valid", 32'(ov1), 32'd0);
      chk("d1 drained out_data", 32'(od1), 32'h1230);

      // DEPTH=2: control bits cleared once the entry has left
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h5A5F, 1'b1);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      tick();
      chk("d2 out_valid", 32'(ov2), 32'd1);
      chk("d2 out_data", 32'(od2), 32'h5A5F);
      tick();
      chk("d2 bubble out_valid", 32'(ov2), 32'd0);
      chk("d2 bubble ctrl", 32'(od2[3:0]), 32'h0);
      chk("d2 bubble upper", 32'(od2[15:4]), 32'h5A5);
      chk("d2 bubble occupancy", 32'(occ2), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
